// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
package lcd_pkg;

  typedef enum logic [1:0] {
    INIT8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } lcd_rx_state_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_SETDD      = 8'h80;

  localparam logic [6:0] ADDR_L1_END   = 7'h27;
  localparam logic [6:0] ADDR_L2_START = 7'h40;
  localparam logic [6:0] ADDR_L2_END   = 7'h67;

  // DDRAM address step on the two-line map; off-map addresses wrap plainly.
  function automatic logic [6:0] lcd_addr_step(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == ADDR_L1_END)      nxt = ADDR_L2_START;
      else if (addr == ADDR_L2_END) nxt = 7'h00;
      else                          nxt = addr + 7'd1;
    end else begin
      if (addr == ADDR_L2_START)    nxt = ADDR_L1_END;
      else if (addr == 7'h00)       nxt = ADDR_L2_END;
      else                          nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Multi-stage synchroniser for the LCD pins plus an E falling-edge detector.
module lcd_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_data,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  output logic       o_fall,
  output logic [3:0] o_data,
  output logic       o_rs,
  output logic       o_rw
);

  // Each stage carries {E, RS, RW, Data[3:0]} so all pins see equal latency.
  logic [6:0] r_sync [SYNC_STAGES];
  logic       r_prev_e;
  logic [6:0] w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 7'h00;
      r_prev_e <= 1'b0;
    end else begin
      r_sync[0] <= {i_e, i_rs, i_rw, i_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev_e <= w_last[6];
    end
  end

  assign o_fall = r_prev_e & ~w_last[6];
  assign o_rs   = w_last[5];
  assign o_rw   = w_last[4];
  assign o_data = w_last[3:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// Listener for the 4-bit LCD bus: rebuilds command/data bytes, tracks the
// DDRAM address and entry mode, and flags protocol errors.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] LCD_Data,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  output logic       CmdValid,
  output logic [7:0] CmdByte,
  output logic       DataValid,
  output logic [7:0] DataByte,
  output logic [6:0] DataAddr,
  output logic       ClearPulse,
  output logic       Mode4Bit,
  output logic       ProtoErr
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic          w_fall;
  logic [3:0]    w_data;
  logic          w_rs;
  logic          w_rw;
  logic          w_wr_edge;
  logic [7:0]    w_byte;
  logic [6:0]    w_addr_next;

  lcd_rx_state_t r_state;
  logic [3:0]    r_hi;
  logic          r_hi_rs;
  logic [TO_W-1:0] r_to_cnt;
  logic [6:0]    r_addr;
  logic          r_id;

  lcd_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (Clk),
    .rst_n  (Rst),
    .i_data (LCD_Data),
    .i_e    (LCD_E),
    .i_rs   (LCD_RS),
    .i_rw   (LCD_RW),
    .o_fall (w_fall),
    .o_data (w_data),
    .o_rs   (w_rs),
    .o_rw   (w_rw)
  );

  assign w_wr_edge   = w_fall & ~w_rw;
  assign w_byte      = {r_hi, w_data};
  assign w_addr_next = lcd_addr_step(r_addr, r_id);

  // CmdValid/DataValid/ClearPulse are one-cycle valid strobes with no ready:
  // the consumer must take CmdByte/DataByte/DataAddr in the strobe cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= INIT8;
      r_hi       <= 4'h0;
      r_hi_rs    <= 1'b0;
      r_to_cnt   <= '0;
      r_addr     <= 7'h00;
      r_id       <= 1'b1;
      CmdValid   <= 1'b0;
      CmdByte    <= 8'h00;
      DataValid  <= 1'b0;
      DataByte   <= 8'h00;
      DataAddr   <= 7'h00;
      ClearPulse <= 1'b0;
      Mode4Bit   <= 1'b0;
      ProtoErr   <= 1'b0;
    end else begin
      CmdValid   <= 1'b0;
      DataValid  <= 1'b0;
      ClearPulse <= 1'b0;
      case (r_state)
        INIT8: begin
          if (w_wr_edge) begin
            if (!w_rs && w_data == 4'h2) begin
              CmdValid <= 1'b1;
              CmdByte  <= 8'h20;
              Mode4Bit <= 1'b1;
              r_state  <= HI;
            end else if (!w_rs && w_data == 4'h3) begin
              CmdValid <= 1'b1;
              CmdByte  <= 8'h30;
            end else begin
              ProtoErr <= 1'b1;
            end
          end
        end
        HI: begin
          if (w_wr_edge) begin
            r_hi     <= w_data;
            r_hi_rs  <= w_rs;
            r_to_cnt <= '0;
            r_state  <= LO;
          end
        end
        LO: begin
          if (w_wr_edge) begin
            if (w_rs == r_hi_rs) begin
              r_state <= HI;
              if (!w_rs) begin
                CmdValid <= 1'b1;
                CmdByte  <= w_byte;
                if ((w_byte & CMD_SETDD) != 8'h00) begin
                  r_addr <= w_byte[6:0];
                end else if (w_byte == CMD_CLEAR) begin
                  r_addr     <= 7'h00;
                  r_id       <= 1'b1;
                  ClearPulse <= 1'b1;
                end else if ((w_byte & CMD_HOME_MASK) == CMD_HOME) begin
                  r_addr <= 7'h00;
                end else if ((w_byte & CMD_ENTRY_MASK) == CMD_ENTRY) begin
                  r_id <= w_byte[1];
                end
              end else begin
                DataValid <= 1'b1;
                DataByte  <= w_byte;
                DataAddr  <= r_addr;
                r_addr    <= w_addr_next;
              end
            end else begin
              // RS flipped mid-byte: resynchronise on this nibble as a new high half.
              ProtoErr <= 1'b1;
              r_hi     <= w_data;
              r_hi_rs  <= w_rs;
              r_to_cnt <= '0;
            end
          end else if (r_to_cnt == TO_LIMIT) begin
            ProtoErr <= 1'b1;
            r_state  <= HI;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= INIT8;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with an expected-strobe queue.
module tb_lcd_bus_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 200;
  localparam int TO_W        = 16;
  localparam int W           = 18;

  logic       clk;
  logic       rst_n;
  logic [3:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       data_valid;
  logic [7:0] data_byte;
  logic [6:0] data_addr;
  logic       clear_pulse;
  logic       mode4;
  logic       proto_err;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  lcd_bus_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W(TO_W)
  ) dut (
    .Clk        (clk),
    .Rst        (rst_n),
    .LCD_Data   (lcd_data),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .CmdValid   (cmd_valid),
    .CmdByte    (cmd_byte),
    .DataValid  (data_valid),
    .DataByte   (data_byte),
    .DataAddr   (data_addr),
    .ClearPulse (clear_pulse),
    .Mode4Bit   (mode4),
    .ProtoErr   (proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish (got timeout, want completion)");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic c, input logic d, input logic clr,
                                      input logic [7:0] b, input logic [6:0] a);
    return {c, d, clr, b, a};
  endfunction

  // scoreboard: every strobe cycle must match the head of the expected queue
  always @(negedge clk) begin
    logic [W-1:0] obs;
    if (rst_n && (cmd_valid || data_valid || clear_pulse)) begin
      obs = {cmd_valid, data_valid, clear_pulse,
             cmd_valid ? cmd_byte : data_byte,
             data_valid ? data_addr : 7'h00};
      if (exp_q.size() == 0) check_val("unexpected_strobe", 32'(obs), 32'h0);
      else                   check_val("strobe", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] n);
    @(negedge clk);
    lcd_data = n;
    lcd_rs   = rs;
    lcd_rw   = rw;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (SYNC_STAGES + 6) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nibble(rs, 1'b0, b[7:4]);
    send_nibble(rs, 1'b0, b[3:0]);
  endtask

  task automatic init_seq();
    exp_q.push_back(ev(1, 0, 0, 8'h30, 7'h00));
    exp_q.push_back(ev(1, 0, 0, 8'h30, 7'h00));
    exp_q.push_back(ev(1, 0, 0, 8'h30, 7'h00));
    exp_q.push_back(ev(1, 0, 0, 8'h20, 7'h00));
    send_nibble(0, 0, 4'h3);
    send_nibble(0, 0, 4'h3);
    send_nibble(0, 0, 4'h3);
    send_nibble(0, 0, 4'h2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    lcd_data = 4'h0;
    lcd_e = 1'b0;
    lcd_rs = 1'b0;
    lcd_rw = 1'b0;
    repeat (4) @(negedge clk);
    check_val("reset_outputs",
              {cmd_valid, data_valid, clear_pulse, cmd_byte, data_byte, data_addr, mode4, proto_err},
              32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    init_seq();
    check_val("mode4_after_init", 32'(mode4), 32'h1);
    check_val("perr_after_init", 32'(proto_err), 32'h0);

    // set address 0x26, then three characters across the line-1/line-2 seam
    exp_q.push_back(ev(1, 0, 0, 8'hA6, 7'h00));
    send_byte(0, 8'hA6);
    exp_q.push_back(ev(0, 1, 0, 8'h41, 7'h26));
    exp_q.push_back(ev(0, 1, 0, 8'h42, 7'h27));
    exp_q.push_back(ev(0, 1, 0, 8'h43, 7'h40));
    send_byte(1, 8'h41);
    send_byte(1, 8'h42);
    send_byte(1, 8'h43);

    // decrement mode from 0x40 back across the seam
    exp_q.push_back(ev(1, 0, 0, 8'h04, 7'h00));
    exp_q.push_back(ev(1, 0, 0, 8'hC0, 7'h00));
    exp_q.push_back(ev(0, 1, 0, 8'h31, 7'h40));
    exp_q.push_back(ev(0, 1, 0, 8'h31, 7'h27));
    send_byte(0, 8'h04);
    send_byte(0, 8'hC0);
    send_byte(1, 8'h31);
    send_byte(1, 8'h31);

    // clear display restores address 0 and increment
    exp_q.push_back(ev(1, 0, 1, 8'h01, 7'h00));
    exp_q.push_back(ev(0, 1, 0, 8'h5A, 7'h00));
    send_byte(0, 8'h01);
    send_byte(1, 8'h5A);
    check_val("perr_before_timeout", 32'(proto_err), 32'h0);

    // lone high nibble then idle past the timeout
    send_nibble(1, 0, 4'h4);
    repeat (TIMEOUT_CYC + 5) @(negedge clk);
    check_val("perr_after_timeout", 32'(proto_err), 32'h1);
    exp_q.push_back(ev(0, 1, 0, 8'h48, 7'h01));
    send_byte(1, 8'h48);

    // read edge must be ignored completely
    send_nibble(0, 1, 4'h0);
    exp_q.push_back(ev(0, 1, 0, 8'h20, 7'h02));
    send_byte(1, 8'h20);
    check_val("queue_drained_1", 32'(exp_q.size()), 32'h0);

    // reset mid-byte
    send_nibble(1, 0, 4'h6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midbyte_reset_outputs",
              {cmd_valid, data_valid, clear_pulse, cmd_byte, data_byte, data_addr, mode4, proto_err},
              32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mode4_after_reset", 32'(mode4), 32'h0);

    init_seq();
    check_val("perr_after_reinit", 32'(proto_err), 32'h0);

    // RS flips between nibbles: error, second nibble becomes the new high half
    send_nibble(0, 0, 4'h4);
    send_nibble(1, 0, 4'h1);
    check_val("perr_rs_change", 32'(proto_err), 32'h1);
    exp_q.push_back(ev(0, 1, 0, 8'h15, 7'h00));
    send_nibble(1, 0, 4'h5);

    repeat (10) @(negedge clk);
    check_val("queue_drained_2", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Listener end of the 4-bit HD44780-style LCD bus that the LCD driver transmits on (LCD_Data, LCD_E, LCD_RS, LCD_RW).
- Synchronises the bus and reassembles nibbles into command and data bytes.
- Tracks the DDRAM address and entry mode, and emits one-cycle strobes per decoded transfer.
- Used as the on-chip checker/monitor beside the LCD driver, and as the bus model in the LCD testbenches.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on every LCD input; legal range 2..4.
- TIMEOUT_CYC, 50000: maximum Clk cycles allowed between the high and low nibble in 4-bit mode.
- TO_W, 16: width of the nibble-timeout counter; must hold TIMEOUT_CYC.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-low reset.
- LCD_Data  in  4  LCD nibble bus, asynchronous to Clk.
- LCD_E  in  1  LCD enable; a transfer is latched on its falling edge.
- LCD_RS  in  1  register select: 0 = command, 1 = data.
- LCD_RW  in  1  1 = read (ignored), 0 = write.
- CmdValid  out  1  one-cycle strobe: CmdByte is valid.
- CmdByte  out  8  last complete command byte.
- DataValid  out  1  one-cycle strobe: DataByte and DataAddr are valid.
- DataByte  out  8  last complete data (character) byte.
- DataAddr  out  7  DDRAM address DataByte was written to.
- ClearPulse  out  1  one-cycle strobe on a clear-display command (0x01).
- Mode4Bit  out  1  1 once the 4-bit interface has been selected.
- ProtoErr  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (Rst=0, asynchronous):
  - All synchroniser flops and the E-history flop go to 0.
  - All outputs go to 0; Mode4Bit=0; address=0; I/D=1 (increment); half-byte flag clear.
  - Reset asserted mid-byte discards the pending nibble.
- Input sampling:
  - All four inputs pass through SYNC_STAGES flops.
  - A falling edge is prev_E=1 and sync_E=0.
  - On that cycle, the synchronised Data/RS/RW values are captured.
  - Strobes are registered, so they rise SYNC_STAGES+1 Clk cycles after LCD_E falls at the pin and stay high for exactly one cycle.
- RW=1 edges: ignored entirely; no state change, no strobe.
- States:
  - INIT8: each write edge is a single nibble N, treated as byte {N,4'h0}.
    - RS=0 and N=0x2 → CmdValid (CmdByte=0x20), Mode4Bit=1, go to HI.
    - RS=0 and N=0x3 → CmdValid (CmdByte=0x30), stay in INIT8.
    - Any other nibble → ProtoErr=1, stay in INIT8.
  - HI: the edge latches the high nibble and its RS value, clears the timeout counter, goes to LO.
  - LO:
    - Edge with the same RS → byte={hi,lo}; decode it, go to HI.
    - Edge with a different RS → ProtoErr=1; that nibble is taken as a new high nibble; stay in LO.
    - Counter reaches TIMEOUT_CYC → drop the half byte, ProtoErr=1, go to HI.
    - Edge and timeout in the same cycle: the edge wins.
- Byte decode, RS=0 (CmdValid pulses for every command):
  - 0x01 → address=0, I/D=1, ClearPulse=1.
  - 0x02 or 0x03 → address=0.
  - 0x04..0x07 → I/D=byte[1].
  - 0x80..0xFF → address=byte[6:0].
  - Any other command is strobed only.
- Byte decode, RS=1:
  - DataValid=1, DataByte=byte, DataAddr=current address.
  - Then the address steps per I/D.
- Address step rules (two-line map):
  - Increment: 0x27→0x40, 0x67→0x00, otherwise +1.
  - Decrement: 0x40→0x27, 0x00→0x67, otherwise −1.
  - Addresses outside the map (set via 0x80 commands) step by plain ±1 with 7-bit wrap.

Decomposition:
- Shared package lcd_pkg:
  - State encoding: INIT8, HI, LO.
  - Command constants: CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_ENTRY_MASK=8'hFC/8'h04, CMD_SETDD=8'h80.
  - Line-map constants: 7'h27, 7'h40, 7'h67.
- One sub-module, lcd_in_sync:
  - Parameterised SYNC_STAGES synchroniser plus E falling-edge detector.
  - Outputs: fall strobe, data, rs, rw.

Test Plan:
- Reset, then nibbles 3,3,3,2 with RS=0 → three CmdValid with CmdByte=0x30, one with CmdByte=0x20; Mode4Bit=1 after the fourth; ProtoErr=0.
- 4-bit mode: send cmd 0x80|0x26, then data 'A','B','C' → DataValid three times at DataAddr 0x26, 0x27, 0x40.
- Send cmd 0x04, then cmd 0xC0, then data 0x31 twice → DataAddr 0x40 then 0x27.
- Send cmd 0x01 → ClearPulse and CmdValid together for one cycle; the next data byte lands at DataAddr 0x00.
- Send high nibble only, then idle TIMEOUT_CYC+5 cycles → ProtoErr=1, no strobe; the next full byte 0x48 with RS=1 decodes correctly.
- RS changes between nibbles → ProtoErr=1. An RW=1 edge → no strobe. Rst pulled low mid-byte → all outputs 0 immediately; Mode4Bit=0 after release.
